// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle sequencer for the MIPS core. Walks the shared ALU, register
//   file and unified instruction/data memory through FETCH/DECODE/EXEC/MEM/WB,
//   stalling on the memory ready handshake. Any access that has stayed
//   not-ready for WAIT_LIMIT cycles is aborted with a one-cycle mem_err.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   op, funct   instr[31:26] / instr[5:0] from the instruction register
//   zero        ALU zero flag (branch qualification)
//   mem_ready   memory completes the current access this cycle
//   state       current state encoding
//   memread, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
//   alucontrol, regdst, memtoreg, regwrite
//               datapath selects and strobes
//   instr_done  one-cycle pulse when an instruction retires
//   illegal     one-cycle pulse on an unsupported op/funct
//   mem_err     one-cycle pulse on a memory timeout
module multicycle_ctrl #(
  parameter int WAIT_W     = 8,
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_LIMIT[WAIT_W-1:0];

  state_t            st, st_nxt;
  logic [WAIT_W-1:0] cnt, cnt_nxt;
  logic              timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= S_FETCH;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign state   = st;
  // Only meaningful in the three waiting states; mem_ready takes priority.
  assign timeout = (cnt == LIMIT) && !mem_ready;

  always_comb begin
    st_nxt     = st;
    cnt_nxt    = '0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = ALU_AND;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    // While reset is held every strobe is forced low, even though the state
    // register already reads FETCH.
    if (reset) begin
      case (st)
        S_FETCH: begin
          memread    = 1'b1;
          alusrcb    = 2'b01;
          alucontrol = ALU_ADD;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            st_nxt  = S_DECODE;
          end else if (timeout) begin
            mem_err = 1'b1;           // retry the fetch, PC untouched
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_DECODE: begin
          alusrcb    = 2'b11;
          alucontrol = ALU_ADD;       // precompute branch target
          case (op)
            OP_LW, OP_SW: st_nxt = S_MEMADR;
            OP_RTYPE:     st_nxt = S_RTYPEEX;
            OP_BEQ:       st_nxt = S_BEQEX;
            OP_ADDI:      st_nxt = S_ADDIEX;
            OP_J:         st_nxt = S_JEX;
            default: begin
              illegal = 1'b1;
              st_nxt  = S_FETCH;
            end
          endcase
        end

        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          st_nxt     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
        end

        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            st_nxt = S_MEMWB;
          end else if (timeout) begin
            mem_err = 1'b1;
            st_nxt  = S_FETCH;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end

        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            st_nxt     = S_FETCH;
          end else if (timeout) begin
            mem_err = 1'b1;
            st_nxt  = S_FETCH;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end

        S_RTYPEEX: begin
          alusrca = 1'b1;
          st_nxt  = S_ALUWB;
          case (funct)
            6'b100000: alucontrol = ALU_ADD;
            6'b100010: alucontrol = ALU_SUB;
            6'b100100: alucontrol = ALU_AND;
            6'b100101: alucontrol = ALU_OR;
            6'b100111: alucontrol = ALU_NOR;
            6'b101010: alucontrol = ALU_SLT;
            default: begin
              illegal = 1'b1;
              st_nxt  = S_FETCH;
            end
          endcase
        end

        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end

        S_BEQEX: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcwrite    = zero;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end

        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = 2'b10;
          alucontrol = ALU_ADD;
          st_nxt     = S_ADDIWB;
        end

        S_ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end

        S_JEX: begin
          pcsrc      = 2'b10;
          pcwrite    = 1'b1;
          instr_done = 1'b1;
          st_nxt     = S_FETCH;
        end

        default: st_nxt = S_FETCH;   // unused encodings 12-15
      endcase
    end
  end

endmodule
